// File: rtl/neo_lb_writer.sv
// neo_lb_writer: sprite line-buffer write controller.
//
// Takes one serialized pixel pair from the zmc2 dot stream per 12 MHz enable.
// It tags each pixel with the current sprite palette and issues one-clock
// registered writes for pixel A and pixel B. Each write goes to its absolute X
// position in the active line-buffer bank.
//
// Ports:
//   CLK, RESET              system clock, asynchronous active-high reset
//   CLK_EN_12M_N            1 on the CLK cycle where a dot pair is consumed
//   LOAD, XPOS, PAL, H      start of a new sprite strip (X, palette, h-flip)
//   LINE_END                end of scanline, swap the write bank
//   GAD, GBD, DOTA, DOTB    pixel A/B colour index and opacity
//   WR_ADDR_A/B             absolute X of pixel A/B
//   WR_DATA_A/B             {palette, index}
//   WR_EN_A/B               one-clock write strobes
//   BANK                    bank targeted by the current write outputs
module neo_lb_writer #(
    parameter int unsigned VISIBLE_W = 320
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CLK_EN_12M_N,
    input  logic        LOAD,
    input  logic [8:0]  XPOS,
    input  logic [7:0]  PAL,
    input  logic        H,
    input  logic        LINE_END,
    input  logic [3:0]  GAD,
    input  logic [3:0]  GBD,
    input  logic        DOTA,
    input  logic        DOTB,
    output logic [8:0]  WR_ADDR_A,
    output logic [8:0]  WR_ADDR_B,
    output logic [11:0] WR_DATA_A,
    output logic [11:0] WR_DATA_B,
    output logic        WR_EN_A,
    output logic        WR_EN_B,
    output logic        BANK
);

    localparam logic [9:0] VIS_LIMIT = VISIBLE_W[9:0];

    logic [8:0]  x_q, x_d;
    logic [7:0]  pal_q, pal_d;
    logic        flip_q, flip_d;
    logic        bank_q, bank_d;

    logic [8:0]  addr_a_q, addr_a_d;
    logic [8:0]  addr_b_q, addr_b_d;
    logic [11:0] data_a_q, data_a_d;
    logic [11:0] data_b_q, data_b_d;
    logic        en_a_q, en_a_d;
    logic        en_b_q, en_b_d;
    logic        bank_out_q;

    // Base position and sprite attributes for this pair. LOAD takes effect
    // for the same pair that it arrives with. Nine-bit arithmetic wraps the
    // X position modulo 512.
    always_comb begin
        x_d      = x_q;
        pal_d    = pal_q;
        flip_d   = flip_q;
        addr_a_d = x_q;
        if (LOAD) begin
            addr_a_d = XPOS;
            pal_d    = PAL;
            flip_d   = H;
        end
        addr_b_d = flip_d ? addr_a_d - 9'd1 : addr_a_d + 9'd1;
        x_d      = flip_d ? addr_a_d - 9'd2 : addr_a_d + 9'd2;
        data_a_d = {pal_d, GAD};
        data_b_d = {pal_d, GBD};
        en_a_d   = DOTA && ({1'b0, addr_a_d} < VIS_LIMIT);
        en_b_d   = DOTB && ({1'b0, addr_b_d} < VIS_LIMIT);
        bank_d   = LINE_END ? ~bank_q : bank_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            x_q        <= '0;
            pal_q      <= '0;
            flip_q     <= 1'b0;
            bank_q     <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            en_a_q     <= 1'b0;
            en_b_q     <= 1'b0;
            bank_out_q <= 1'b0;
        end else if (CLK_EN_12M_N) begin
            x_q        <= x_d;
            pal_q      <= pal_d;
            flip_q     <= flip_d;
            bank_q     <= bank_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            en_a_q     <= en_a_d;
            en_b_q     <= en_b_d;
            // The write on a LINE_END enable still targets the old bank.
            bank_out_q <= bank_q;
        end else begin
            en_a_q <= 1'b0;
            en_b_q <= 1'b0;
        end
    end

    assign WR_ADDR_A = addr_a_q;
    assign WR_ADDR_B = addr_b_q;
    assign WR_DATA_A = data_a_q;
    assign WR_DATA_B = data_b_q;
    assign WR_EN_A   = en_a_q;
    assign WR_EN_B   = en_b_q;
    assign BANK      = bank_out_q;

endmodule

// File: tb/tb_neo_lb_writer.sv
module tb_neo_lb_writer;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [8:0]  xpos;
    logic [7:0]  pal;
    logic        h;
    logic        line_end;
    logic [3:0]  gad, gbd;
    logic        dota, dotb;
    logic [8:0]  wr_addr_a, wr_addr_b;
    logic [11:0] wr_data_a, wr_data_b;
    logic        wr_en_a, wr_en_b;
    logic        bank;

    int checks = 0;
    int errors = 0;

    neo_lb_writer #(.VISIBLE_W(320)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .CLK_EN_12M_N (en),
        .LOAD         (load),
        .XPOS         (xpos),
        .PAL          (pal),
        .H            (h),
        .LINE_END     (line_end),
        .GAD          (gad),
        .GBD          (gbd),
        .DOTA         (dota),
        .DOTB         (dotb),
        .WR_ADDR_A    (wr_addr_a),
        .WR_ADDR_B    (wr_addr_b),
        .WR_DATA_A    (wr_data_a),
        .WR_DATA_B    (wr_data_b),
        .WR_EN_A      (wr_en_a),
        .WR_EN_B      (wr_en_b),
        .BANK         (bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One enable carrying a dot pair; outputs are sampled 1ns after the edge.
    task automatic pair(input logic ld, input logic [8:0] x, input logic [7:0] p,
                        input logic hf, input logic le, input logic [3:0] a,
                        input logic [3:0] b, input logic da, input logic db);
        @(negedge clk);
        en = 1'b1; load = ld; xpos = x; pal = p; h = hf; line_end = le;
        gad = a; gbd = b; dota = da; dotb = db;
        @(posedge clk);
        #1;
        en = 1'b0; load = 1'b0; line_end = 1'b0;
    endtask

    task automatic expect_wr(input string tag, input logic [8:0] aa, input logic [8:0] ab,
                             input logic ea, input logic eb);
        check({tag, "_addr_a"}, 32'(wr_addr_a), 32'(aa));
        check({tag, "_addr_b"}, 32'(wr_addr_b), 32'(ab));
        check({tag, "_en_a"}, 32'(wr_en_a), 32'(ea));
        check({tag, "_en_b"}, 32'(wr_en_b), 32'(eb));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; xpos = '0; pal = '0; h = 1'b0;
        line_end = 1'b0; gad = '0; gbd = '0; dota = 1'b0; dotb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        expect_wr("reset", 9'd0, 9'd0, 1'b0, 1'b0);
        check("reset_data_a", 32'(wr_data_a), 32'h0);
        check("reset_bank", 32'(bank), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Basic run
        pair(1'b1, 9'd10, 8'h25, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 1'b1);
        expect_wr("basic0", 9'd10, 9'd11, 1'b1, 1'b1);
        check("basic0_data_a", 32'(wr_data_a), 32'h251);
        check("basic0_data_b", 32'(wr_data_b), 32'h252);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd3, 4'd4, 1'b1, 1'b1);
        expect_wr("basic1", 9'd12, 9'd13, 1'b1, 1'b1);
        check("basic1_data_b", 32'(wr_data_b), 32'h254);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd5, 4'd6, 1'b1, 1'b1);
        expect_wr("basic2", 9'd14, 9'd15, 1'b1, 1'b1);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd7, 4'd8, 1'b1, 1'b1);
        expect_wr("basic3", 9'd16, 9'd17, 1'b1, 1'b1);
        check("basic3_data_a", 32'(wr_data_a), 32'h257);

        // No enable: strobes drop, address/data hold
        @(posedge clk);
        #1;
        expect_wr("idle", 9'd16, 9'd17, 1'b0, 1'b0);
        check("idle_data_b", 32'(wr_data_b), 32'h258);

        // Flip
        pair(1'b1, 9'd100, 8'h3C, 1'b1, 1'b0, 4'd9, 4'd10, 1'b1, 1'b1);
        expect_wr("flip0", 9'd100, 9'd99, 1'b1, 1'b1);
        check("flip0_data_a", 32'(wr_data_a), 32'h3C9);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        expect_wr("flip1", 9'd98, 9'd97, 1'b1, 1'b1);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd1, 4'd1, 1'b1, 1'b1);
        expect_wr("flip2", 9'd96, 9'd95, 1'b1, 1'b1);

        // Transparency; index 0 with DOTA=1 still writes
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd0, 4'd5, 1'b1, 1'b0);
        expect_wr("transp", 9'd94, 9'd93, 1'b1, 1'b0);
        check("transp_data_a", 32'(wr_data_a), 32'h3C0);
        check("transp_data_b", 32'(wr_data_b), 32'h3C5);

        // Right-edge clipping
        pair(1'b1, 9'd318, 8'h11, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1, 1'b1);
        expect_wr("clip0", 9'd318, 9'd319, 1'b1, 1'b1);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd2, 4'd3, 1'b1, 1'b1);
        expect_wr("clip1", 9'd320, 9'd321, 1'b0, 1'b0);
        check("clip1_data_a", 32'(wr_data_a), 32'h112);

        // Wrap forward
        pair(1'b1, 9'd511, 8'h07, 1'b0, 1'b0, 4'd4, 4'd5, 1'b1, 1'b1);
        expect_wr("wrap0", 9'd511, 9'd0, 1'b0, 1'b1);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd4, 4'd5, 1'b1, 1'b1);
        expect_wr("wrap1", 9'd1, 9'd2, 1'b1, 1'b1);

        // Wrap backward (mirror)
        pair(1'b1, 9'd0, 8'h07, 1'b1, 1'b0, 4'd4, 4'd5, 1'b1, 1'b1);
        expect_wr("mirror", 9'd0, 9'd511, 1'b1, 1'b0);

        // Back-to-back LOADs on consecutive enables
        @(negedge clk);
        en = 1'b1; load = 1'b1; xpos = 9'd200; pal = 8'hA0; h = 1'b0;
        gad = 4'd6; gbd = 4'd7; dota = 1'b1; dotb = 1'b1;
        @(posedge clk);
        #1;
        expect_wr("b2b0", 9'd200, 9'd201, 1'b1, 1'b1);
        xpos = 9'd40; pal = 8'hB0; h = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0; load = 1'b0;
        expect_wr("b2b1", 9'd40, 9'd39, 1'b1, 1'b1);
        check("b2b1_data_a", 32'(wr_data_a), 32'hB06);

        // LOAD and LINE_END together
        pair(1'b1, 9'd50, 8'h42, 1'b0, 1'b1, 4'd1, 4'd2, 1'b1, 1'b1);
        expect_wr("sim0", 9'd50, 9'd51, 1'b1, 1'b1);
        check("sim0_bank", 32'(bank), 32'h0);
        pair(1'b0, 9'd0, 8'h00, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 1'b1);
        expect_wr("sim1", 9'd52, 9'd53, 1'b1, 1'b1);
        check("sim1_bank", 32'(bank), 32'h1);

        // Asynchronous reset mid-strip
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        expect_wr("arst", 9'd0, 9'd0, 1'b0, 1'b0);
        check("arst_data_a", 32'(wr_data_a), 32'h0);
        check("arst_bank", 32'(bank), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pair(1'b0, 9'd0, 8'hFF, 1'b1, 1'b0, 4'd9, 4'd10, 1'b1, 1'b1);
        expect_wr("post_rst", 9'd0, 9'd1, 1'b1, 1'b1);
        check("post_rst_data_a", 32'(wr_data_a), 32'h009);
        check("post_rst_data_b", 32'(wr_data_b), 32'h00A);
        check("post_rst_bank", 32'(bank), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
